// File: rtl/eng_ctl_pkg.sv
// Shared definitions for the encoding-engine job sequencer: default sizes
// and the sequencer state encoding.
package eng_ctl_pkg;

  localparam int CNT_W     = 16;
  localparam int OUTST_MAX = 4;
  localparam int CFG_WAIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERST  = 3'd1,
    ST_CFG   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } eng_seq_state_t;

endpackage

// File: rtl/eng_wr_credit.sv
// Outstanding engine-write credit counter: up on each write request, down on
// each acknowledge, with a limit compare that gates further engine progress.
module eng_wr_credit #(
  parameter int OUTST_MAX = eng_ctl_pkg::OUTST_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic dec_ok,
  output logic credit_avail
);

  localparam int CR_W = $clog2(OUTST_MAX + 1);

  logic [CR_W-1:0] credit_q, credit_d;

  // An acknowledge with nothing outstanding is spurious and must not underflow.
  assign dec_ok       = dec && (credit_q != '0);
  assign credit_avail = credit_q < CR_W'(OUTST_MAX);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    credit_d = credit_q;
    if (clear) begin
      credit_d = '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   credit_d = credit_q + CR_W'(1);
        2'b01:   credit_d = credit_q - CR_W'(1);
        default: credit_d = credit_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

endmodule

// File: rtl/engine_seq_cntl.sv
// Job-level sequencer for the encoding engine: engine reset, config strobe,
// gated input beats, and drain until all output writes are acknowledged.
module engine_seq_cntl #(
  parameter int CNT_W     = eng_ctl_pkg::CNT_W,
  parameter int OUTST_MAX = eng_ctl_pkg::OUTST_MAX,
  parameter int CFG_WAIT  = eng_ctl_pkg::CFG_WAIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_start,
  input  logic [CNT_W-1:0] job_words,
  input  logic             job_abort,
  output logic             job_busy,
  output logic             job_done,
  output logic             job_err,
  output logic             eng_rstn,
  output logic             cfg_wr,
  output logic             global_reg_wr_en,
  output logic             cntrl_eng_calc_en,
  output logic             cntl_eng_bm_col_din_reg_val,
  input  logic             data_used,
  input  logic             eng_pl_empty,
  input  logic             eng_outbuf_wr_req,
  input  logic             outbuf_eng_wr_ack,
  input  logic             outbuf_eng_full,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] ack_cnt
);

  import eng_ctl_pkg::*;

  localparam int                WAIT_W    = (CFG_WAIT > 1) ? $clog2(CFG_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CFG_WAIT - 1);

  eng_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic eng_rstn_q, eng_rstn_d, cfg_wr_q, cfg_wr_d, glob_q, glob_d;
  logic run_or_drain, start_take, abort_take, ack_ok, credit_avail;

  assign run_or_drain = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  eng_wr_credit #(.OUTST_MAX(OUTST_MAX)) u_credit (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_take),
    .inc          (eng_outbuf_wr_req && run_or_drain),
    .dec          (outbuf_eng_wr_ack && run_or_drain),
    .dec_ok       (ack_ok),
    .credit_avail (credit_avail)
  );

  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    in_cnt_d   = in_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    wait_d     = wait_q;
    start_take = 1'b0;
    abort_take = 1'b0;

    case (state_q)
      ST_IDLE: if (job_start) begin
        state_d    = ST_ERST;
        words_d    = job_words;
        in_cnt_d   = '0;
        ack_cnt_d  = '0;
        start_take = 1'b1;
      end
      ST_ERST: begin
        state_d = ST_CFG;
        wait_d  = '0;
      end
      ST_CFG: begin
        if (wait_q == WAIT_LAST) state_d = (words_q == '0) ? ST_DONE : ST_RUN;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      ST_RUN: if (data_used) begin
        in_cnt_d = in_cnt_q + CNT_W'(1);
        if (in_cnt_q + CNT_W'(1) == words_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: if ((ack_cnt_q == words_q) && eng_pl_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (ack_ok) ack_cnt_d = ack_cnt_q + CNT_W'(1);

    // Abort overrides normal sequencing; the DONE cycle then carries the error.
    if (job_abort && (state_q inside {ST_ERST, ST_CFG, ST_RUN, ST_DRAIN})) begin
      abort_take = 1'b1;
      state_d    = ST_DONE;
    end

    // Registered outputs are decoded from the next state so they align with it.
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    err_d      = abort_take;
    eng_rstn_d = !((state_d == ST_ERST) || abort_take);
    cfg_wr_d   = (state_q == ST_ERST) && (state_d == ST_CFG);
    glob_d     = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      words_q    <= '0;
      in_cnt_q   <= '0;
      ack_cnt_q  <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      eng_rstn_q <= 1'b1;
      cfg_wr_q   <= 1'b0;
      glob_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      in_cnt_q   <= in_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      eng_rstn_q <= eng_rstn_d;
      cfg_wr_q   <= cfg_wr_d;
      glob_q     <= glob_d;
    end
  end

  assign job_busy                    = busy_q;
  assign job_done                    = done_q;
  assign job_err                     = err_q;
  assign eng_rstn                    = eng_rstn_q;
  assign cfg_wr                      = cfg_wr_q;
  assign global_reg_wr_en            = glob_q;
  assign in_cnt                      = in_cnt_q;
  assign ack_cnt                     = ack_cnt_q;
  assign cntrl_eng_calc_en           = run_or_drain && !outbuf_eng_full && credit_avail;
  assign cntl_eng_bm_col_din_reg_val = (state_q == ST_RUN);

endmodule

// File: doc/engine_seq_cntl.md
Name: engine_seq_cntl

Overview:
- Job-level sequencer for the encoding engine.
- Per job: resets the engine pipeline, strobes the engine's configuration registers, gates `cntrl_eng_calc_en` and the bitmatrix-column valid so exactly `job_words` input beats enter, and drains until every output write is acknowledged.
- Applies outbuf back-pressure through full status and an outstanding-write credit limit.
- Sits between host/control registers and engine_top.

Parameters:
- CNT_W, 16, width of the job word count and of the beat counters.
- OUTST_MAX, 4, maximum engine output writes issued but not yet acknowledged by outbuf (≥1).
- CFG_WAIT, 2, cycles spent in CFG after the config strobe, before RUN (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- job_start  in  1  start pulse; accepted only in IDLE
- job_words  in  CNT_W  input beats in the job; sampled on accepted job_start
- job_abort  in  1  abort the current job; ignored in IDLE
- job_busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse at job end
- job_err  out  1  valid with job_done; 1 = aborted
- eng_rstn  out  1  engine synchronous pipeline clear, active low
- cfg_wr  out  1  drives bmu_bm_mux_sel_reg_wr and and_mask_mask_reg_wr
- global_reg_wr_en  out  1  high only in IDLE (config registers writable by host)
- cntrl_eng_calc_en  out  1  engine advance enable
- cntl_eng_bm_col_din_reg_val  out  1  bitmatrix columns valid
- data_used  in  1  engine consumed one input beat
- eng_pl_empty  in  1  engine holds no valid stage
- eng_outbuf_wr_req  in  1  engine issued an output write this cycle
- outbuf_eng_wr_ack  in  1  outbuf acknowledges one earlier write; at most one per cycle
- outbuf_eng_full  in  1  outbuf full
- in_cnt  out  CNT_W  beats consumed in the current job
- ack_cnt  out  CNT_W  writes acknowledged in the current job

Behaviour:
- Reset values (rst=1, async):
  - state=IDLE; in_cnt=0, ack_cnt=0, credit=0.
  - job_busy=0, job_done=0, job_err=0, cfg_wr=0.
  - eng_rstn=1, global_reg_wr_en=1, cntrl_eng_calc_en=0, cntl_eng_bm_col_din_reg_val=0.
- All outputs are registered except cntrl_eng_calc_en and cntl_eng_bm_col_din_reg_val, which are combinational from registered state/counters and outbuf_eng_full. No comb path exists from data_used, eng_outbuf_wr_req or ack to any output.
- FSM states: IDLE, ERST, CFG, RUN, DRAIN, DONE.
  - IDLE: job_start → ERST. Latch job_words; clear in_cnt, ack_cnt, credit.
  - ERST: eng_rstn=0 for exactly 1 cycle → CFG.
  - CFG: cfg_wr=1 on the first CFG cycle only, then stay CFG_WAIT cycles total. Next state is DONE if words==0, else RUN.
  - RUN: cntl_eng_bm_col_din_reg_val=1. On a data_used cycle where in_cnt+1==words → DRAIN.
  - DRAIN: bm_col_val=0. Calc_en continues so the pipeline flushes. When ack_cnt==words and eng_pl_empty → DONE.
  - DONE: job_done=1, job_err=0 for 1 cycle → IDLE.
- cntrl_eng_calc_en is 1 only in RUN/DRAIN, ~outbuf_eng_full, and credit < OUTST_MAX.
- Counters:
  - in_cnt increments on data_used, in RUN only.
  - credit updates by +eng_outbuf_wr_req −outbuf_eng_wr_ack. Simultaneous req and ack leaves it unchanged.
  - ack_cnt increments on outbuf_eng_wr_ack.
- Error cases:
  - Ack with credit==0: ignored, counters unchanged.
  - data_used outside RUN: ignored.
- Abort:
  - job_abort in ERST/CFG/RUN/DRAIN → next cycle eng_rstn=0 for 1 cycle, job_done=1 with job_err=1 in the same cycle → IDLE.
  - Counters hold their values until the next start.
  - Abort in DONE is ignored.
- job_start while busy is ignored.
- Counter width: words up to 2^CNT_W−1. No wrap within a job.
- Mid-job rst: immediate return to reset values; no done pulse.

Decomposition:
- Shared package eng_ctl_pkg:
  - state enum eng_seq_state_t (6 states, 3 bits);
  - localparam CNT_W;
  - OUTST_MAX default.
- One sub-module, eng_wr_credit: an up/down credit counter with a limit compare. Inputs: inc, dec, clear. Output: credit_avail (credit < OUTST_MAX).

Test Plan:
- Basic job: words=5, ack returned 1 cycle after each wr_req, full=0. Expect:
  - eng_rstn low 1 cycle, then cfg_wr 1 cycle;
  - RUN for 5 data_used, then DRAIN;
  - job_done 1 cycle after ack_cnt==5 and eng_pl_empty; job_err=0; in_cnt=5.
- Zero words: words=0 → ERST, CFG, DONE. Calc_en never asserted; job_done=1.
- Credit stall: OUTST_MAX=4, acks withheld. Expect:
  - calc_en drops the cycle after the 4th wr_req;
  - one ack → calc_en returns next cycle;
  - simultaneous req+ack keeps credit=4−1+1.
- Full back-pressure: outbuf_eng_full held 10 cycles mid-RUN. Expect calc_en=0 for exactly those cycles; in_cnt frozen; job still completes with in_cnt=words.
- Abort in RUN at in_cnt=3 of words=8. Expect:
  - next cycle job_done=1, job_err=1, eng_rstn=0 for 1 cycle; IDLE after;
  - a job_start issued during abort is ignored;
  - a new job_start afterward runs cleanly.
- Async rst asserted in DRAIN: all outputs at reset values immediately; no job_done; a subsequent job with words=2 completes normally.
